fir_yout_wb_buffer: RTL and testbench

FIR_YOUT_WB_BUFFER -- requirements
Module: fir_yout_wb_buffer

---
 rtl/fir_yout_wb_buffer.sv | 167 ++++++++++++++++
 tb/tb_fir_yout_wb_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_yout_wb_buffer.sv
// Wishbone-readable FIFO that buffers FIR AXI-Stream output beats ({tlast, tdata}).
// Provides a pop register with bounded wait-for-data, a status/clear register and a last-beat interrupt.
module fir_yout_wb_buffer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DATA_ADDR = 32'h3000_0084,
    parameter logic [31:0] STAT_ADDR = 32'h3000_0090,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        sm_tvalid,
    input  logic [31:0] sm_tdata,
    input  logic        sm_tlast,
    output logic        sm_tready,
    output logic        irq_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          last_seen_q, last_seen_d;
    logic          underflow_q, underflow_d;

    logic          push, pop;
    logic          clr_last, clr_uf, set_uf;
    logic          is_data, is_stat, req, full, empty;
    logic [32:0]   head;
    logic [31:0]   status;
    logic          unused_bits;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign sm_tready = !full;
    assign push      = sm_tvalid && !full;
    assign head      = mem_q[rd_ptr_q];

    assign is_data = (wbs_adr_i == DATA_ADDR);
    assign is_stat = (wbs_adr_i == STAT_ADDR);
    assign req     = wbs_cyc_i && wbs_stb_i && (is_data || is_stat);
    assign status  = {16'h0, 8'(count_q), 4'h0, underflow_q, last_seen_q, full, empty};

    assign unused_bits = ^{head[32], wbs_sel_i[3:1], wbs_dat_i[31:4], wbs_dat_i[1:0]};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = 1'b0;
        dat_d      = '0;
        pop        = 1'b0;
        clr_last   = 1'b0;
        clr_uf     = 1'b0;
        set_uf     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_data && !wbs_we_i) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            ack_d   = 1'b1;
                            dat_d   = head[31:0];
                            state_d = ACK;
                        end else begin
                            wait_cnt_d = '0;
                            state_d    = WAIT;
                        end
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (is_stat && !wbs_we_i) dat_d = status;
                        if (is_stat && wbs_we_i && wbs_sel_i[0]) begin
                            clr_last = wbs_dat_i[2];
                            clr_uf   = wbs_dat_i[3];
                        end
                    end
                end
            end
            WAIT: begin
                if (!(wbs_cyc_i && wbs_stb_i)) begin
                    state_d = IDLE;
                end else if (!empty) begin
                    pop     = 1'b1;
                    ack_d   = 1'b1;
                    dat_d   = head[31:0];
                    state_d = ACK;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    ack_d   = 1'b1;
                    set_uf  = 1'b1;
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            // The still-asserted request is ignored here, so the master sees one idle cycle.
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A newly pushed last beat wins over a clear issued in the same cycle.
    assign last_seen_d = (last_seen_q && !clr_last) || (push && sm_tlast);
    assign underflow_d = (underflow_q && !clr_uf) || set_uf;

    // NOTE: storage is left unreset; the pointers and count alone decide what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {sm_tlast, sm_tdata};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_cnt_q  <= '0;
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            last_seen_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            last_seen_q <= last_seen_d;
            underflow_q <= underflow_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = last_seen_q;

endmodule

// File: tb/tb_fir_yout_wb_buffer.sv
// Directed bench for fir_yout_wb_buffer: a queue scoreboard holds pushed beats in order
// and each DATA read pops its expected value; a small flag model predicts the status word.
module tb_fir_yout_wb_buffer;

    localparam logic [31:0] DATA = 32'h3000_0084;
    localparam logic [31:0] STAT = 32'h3000_0090;
    localparam int          TMO  = 255;
    localparam int          DEP  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic        sm_tready, irq_o;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] sb[$];
    int          mdl_cnt = 0;
    logic        mdl_ls = 1'b0;
    logic        mdl_uf = 1'b0;
    logic        mon_en = 1'b0;
    logic        leak = 1'b0;

    fir_yout_wb_buffer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .sm_tvalid(tvalid),
        .sm_tdata (tdata),
        .sm_tlast (tlast),
        .sm_tready(sm_tready),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && !wbs_ack_o && wbs_dat_o !== 32'h0) leak = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_status();
        logic [7:0] c;
        c = 8'(mdl_cnt);
        return {16'h0, c, 4'h0, mdl_uf, mdl_ls, (mdl_cnt == DEP), (mdl_cnt == 0)};
    endfunction

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat,
                           output logic rdy);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; rd = '0; rdy = 1'b0;
        do begin
            tick();
            lat++;
        end while (!wbs_ack_o && lat < 400);
        if (wbs_ack_o) begin
            rd  = wbs_dat_o;
            rdy = sm_tready;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
        tick();
    endtask

    task automatic read_data(input string tag, input int lo, input int hi, output logic rdy);
        logic [31:0] d, exp;
        int lat;
        wb_xfer(DATA, 1'b0, '0, 4'hF, d, lat, rdy);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            mdl_cnt--;
        end else begin
            exp = '0;
            mdl_uf = 1'b1;
        end
        check({tag, "_data"}, d, exp);
        check({tag, "_lat_in_range"}, (lat >= lo && lat <= hi), 1'b1);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d;
        int lat;
        logic rdy;
        wb_xfer(STAT, 1'b0, '0, 4'hF, d, lat, rdy);
        check(tag, d, exp_status());
    endtask

    task automatic write_stat(input string tag, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        logic rdy;
        wb_xfer(STAT, 1'b1, d, s, rd, lat, rdy);
        if (s[0]) begin
            if (d[2]) mdl_ls = 1'b0;
            if (d[3]) mdl_uf = 1'b0;
        end
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic push_beat(input logic [31:0] d, input logic last);
        check("push_tready", sm_tready, (mdl_cnt != DEP));
        tvalid = 1'b1; tdata = d; tlast = last;
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        if (mdl_cnt != DEP) begin
            sb.push_back(d);
            mdl_cnt++;
            if (last) mdl_ls = 1'b1;
        end
    endtask

    initial begin
        logic rdy;
        int acc, acks;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        check("rst_ack", wbs_ack_o, 1'b0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_tready", sm_tready, 1'b1);
        read_status("rst_status");

        // Unmapped address: never acked, no state change
        cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0088;
        acks = 0;
        repeat (5) begin
            tick();
            if (wbs_ack_o) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("bad_addr_no_ack", acks, 0);

        // Basic ordering and last-beat interrupt
        push_beat(32'd3, 1'b0);
        push_beat(32'd5, 1'b0);
        check("irq_before_last", irq_o, 1'b0);
        push_beat(32'hFFFF_FFF9, 1'b1);
        check("irq_after_last", irq_o, 1'b1);
        read_data("rd_3", 1, 1, rdy);
        read_data("rd_5", 1, 1, rdy);
        read_data("rd_m7", 1, 1, rdy);
        read_status("status_last_seen");
        write_stat("clr_wrong_lane", 32'h4, 4'b0010);
        check("irq_kept_sel0_low", irq_o, 1'b1);
        write_stat("clr_last", 32'h4, 4'b0001);
        check("irq_cleared", irq_o, 1'b0);

        // Fill to full with tvalid held high and 9 beats on offer
        tvalid = 1'b1; tdata = 32'h101; acc = 0;
        for (int c = 0; c < 20 && acc < DEP; c++) begin
            rdy = sm_tready;
            tick();
            if (rdy) begin
                sb.push_back(tdata);
                mdl_cnt++;
                acc++;
                tdata = 32'h101 + acc;
            end
        end
        check("full_accepted", acc, DEP);
        check("full_tready_low", sm_tready, 1'b0);
        read_status("status_full");
        read_data("full_pop", 1, 1, rdy);
        check("slot_freed_tready", rdy, 1'b1);
        sb.push_back(tdata);
        mdl_cnt++;
        tvalid = 1'b0;
        read_status("status_refull");
        for (int i = 0; i < DEP; i++) read_data("drain_full", 1, 1, rdy);

        // Read on empty, beat arrives 10 cycles later
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = DATA;
        acks = 0;
        repeat (10) begin
            tick();
            if (wbs_ack_o) acks++;
        end
        check("wait_no_early_ack", acks, 0);
        tvalid = 1'b1; tdata = 32'd42; tlast = 1'b0;
        tick();
        tvalid = 1'b0;
        sb.push_back(32'd42);
        mdl_cnt++;
        check("wait_no_ack_at_push", wbs_ack_o, 1'b0);
        tick();
        check("wait_ack_after_push", wbs_ack_o, 1'b1);
        check("wait_data_42", wbs_dat_o, sb.pop_front());
        mdl_cnt--;
        cyc = 1'b0; stb = 1'b0;
        tick();
        read_status("status_no_underflow");

        // Timeout on empty FIFO
        read_data("timeout", TMO, TMO + 2, rdy);
        read_status("status_underflow");
        write_stat("clr_uf", 32'h8, 4'b0001);
        read_status("status_uf_cleared");

        // Simultaneous push/pop at count 4 under back-to-back reads
        for (int i = 0; i < 4; i++) push_beat(32'h200 + i, 1'b0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = DATA;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                tvalid = 1'b1;
                tdata  = 32'h210 + i;
                sb.push_back(tdata);
            end else begin
                tvalid = 1'b0;
            end
            tick();
            check("b2b_ack_pattern", wbs_ack_o, (i % 2 == 0));
            if (i % 2 == 0) check("b2b_order", wbs_dat_o, sb.pop_front());
        end
        tvalid = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        tick();
        read_status("status_count4");
        for (int i = 0; i < 4; i++) read_data("drain_b2b", 1, 1, rdy);

        // Reset while waiting on empty FIFO
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = DATA;
        repeat (3) tick();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        acks = 0;
        repeat (3) begin
            tick();
            if (wbs_ack_o) acks++;
        end
        check("rst_wait_no_ack", acks, 0);

        // Reset with 5 buffered beats
        for (int i = 0; i < 5; i++) push_beat(32'h300 + i, (i == 4));
        check("irq_before_rst", irq_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        mdl_cnt = 0; mdl_ls = 1'b0; mdl_uf = 1'b0;
        tick();
        check("rst5_irq", irq_o, 1'b0);
        check("rst5_tready", sm_tready, 1'b1);
        check("rst5_ack", wbs_ack_o, 1'b0);
        read_status("rst5_status");
        push_beat(32'h77, 1'b0);
        read_data("post_rst_fresh", 1, 1, rdy);

        check("dat_zero_without_ack", leak, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
